// File: rtl/frame_sequencer.sv
// frame_sequencer
//   Per-frame control sequencer. Captures a pose (x, y, angle) either from
//   three manual key presses or, in auto mode, directly from pose_*, then runs
//   three client stages in turn: level loader (LL), draw grid (DG) and
//   raytracer (RT). Each stage gets a one-cycle start pulse and is awaited
//   through its done input. The shared grid port is muxed to whichever
//   client's WAIT_* state is active.
//
// Ports
//   clock, reset            sole clock; synchronous active-high reset
//   key_n[2:0]              active-low load keys (0 = X, 1 = Y, 2 = angle)
//   data                    manual pose data
//   auto_mode               1 = run frames back-to-back using pose_*
//   pose_x/pose_y/pose_angle auto-mode pose
//   level                   level select; auto mode skips LL while unchanged
//   ll/dg/rt_start          one-cycle stage start pulses (combinational)
//   ll/dg/rt_done           stage done, level-sampled in matching WAIT_*
//   ll_gx/gy/gin/gwrite     level-loader grid port (read/write)
//   dg_gx/gy, rt_gx/gy      read-only client grid addresses
//   grid_x/y/in/write       muxed grid port (combinational)
//   x, y, angle             registered pose
//   frame_done              one-cycle pulse per completed frame
//   frame_count             completed frames, wraps 255 -> 0
//   busy                    high in any START_*/WAIT_* stage state
//   timeout_err             sticky stage watchdog flag
//   state_dbg               current state encoding
//
// Build option
//   FRAME_SEQUENCER_TIMEOUT_EN  enables the per-stage watchdog; a stage that
//   stays busy for TIMEOUT_CYCLES cycles sets timeout_err and the frame is
//   abandoned via DONE without being counted. Undefined: timeout_err = 0 and
//   stages are awaited indefinitely.

module frame_sequencer #(
  parameter int unsigned DATA_WIDTH     = 14,
  parameter int unsigned X_WIDTH        = 14,
  parameter int unsigned Y_WIDTH        = 13,
  parameter int unsigned ANGLE_WIDTH    = 8,
  parameter int unsigned GX_WIDTH       = 6,
  parameter int unsigned GY_WIDTH       = 5,
  parameter int unsigned CELL_WIDTH     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [2:0]             key_n,
  input  logic [DATA_WIDTH-1:0]  data,
  input  logic                   auto_mode,
  input  logic [X_WIDTH-1:0]     pose_x,
  input  logic [Y_WIDTH-1:0]     pose_y,
  input  logic [ANGLE_WIDTH-1:0] pose_angle,
  input  logic [1:0]             level,
  output logic                   ll_start,
  output logic                   dg_start,
  output logic                   rt_start,
  input  logic                   ll_done,
  input  logic                   dg_done,
  input  logic                   rt_done,
  input  logic [GX_WIDTH-1:0]    ll_gx,
  input  logic [GY_WIDTH-1:0]    ll_gy,
  input  logic [CELL_WIDTH-1:0]  ll_gin,
  input  logic                   ll_gwrite,
  input  logic [GX_WIDTH-1:0]    dg_gx,
  input  logic [GY_WIDTH-1:0]    dg_gy,
  input  logic [GX_WIDTH-1:0]    rt_gx,
  input  logic [GY_WIDTH-1:0]    rt_gy,
  output logic [GX_WIDTH-1:0]    grid_x,
  output logic [GY_WIDTH-1:0]    grid_y,
  output logic [CELL_WIDTH-1:0]  grid_in,
  output logic                   grid_write,
  output logic [X_WIDTH-1:0]     x,
  output logic [Y_WIDTH-1:0]     y,
  output logic [ANGLE_WIDTH-1:0] angle,
  output logic                   frame_done,
  output logic [7:0]             frame_count,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [3:0]             state_dbg
);

  if (X_WIDTH > DATA_WIDTH || Y_WIDTH > DATA_WIDTH || ANGLE_WIDTH > DATA_WIDTH ||
      TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("frame_sequencer: pose widths must fit DATA_WIDTH and TIMEOUT_CYCLES must be nonzero");
  end

  typedef enum logic [3:0] {
    WAIT_X   = 4'd0,
    LOAD_X   = 4'd1,
    WAIT_Y   = 4'd2,
    LOAD_Y   = 4'd3,
    WAIT_A   = 4'd4,
    LOAD_A   = 4'd5,
    START_LL = 4'd6,
    WAIT_LL  = 4'd7,
    START_DG = 4'd8,
    WAIT_DG  = 4'd9,
    START_RT = 4'd10,
    WAIT_RT  = 4'd11,
    DONE     = 4'd12
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  state_t                 w_auto_first;
  logic [X_WIDTH-1:0]     r_x;
  logic [Y_WIDTH-1:0]     r_y;
  logic [ANGLE_WIDTH-1:0] r_angle;
  logic                   r_frame_done;
  logic [7:0]             r_frame_count;
  logic                   r_busy;
  logic [1:0]             r_level;
  logic                   r_level_vld;
  logic                   w_in_wait;
  logic                   w_in_start;
  logic                   w_stage_done;
  logic                   w_timeout;

  // Auto frames skip the level loader while the requested level matches the
  // one held by the last level load that actually completed.
  assign w_auto_first = (r_level_vld && (level == r_level)) ? START_DG : START_LL;

  assign w_in_wait  = (r_state == WAIT_LL) || (r_state == WAIT_DG) || (r_state == WAIT_RT);
  assign w_in_start = (r_state == START_LL) || (r_state == START_DG) || (r_state == START_RT);

  always_comb begin
    w_stage_done = 1'b0;
    case (r_state)
      WAIT_LL: w_stage_done = ll_done;
      WAIT_DG: w_stage_done = dg_done;
      WAIT_RT: w_stage_done = rt_done;
      default: w_stage_done = 1'b0;
    endcase
  end

`ifdef FRAME_SEQUENCER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_wd_cnt;
  logic             r_timeout_err;

  // Counter is zero on the first cycle of every WAIT_* state because each one
  // is entered only from its START_* state.
  assign w_timeout = w_in_wait && !w_stage_done &&
                     (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wd_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_in_start) begin
        r_wd_cnt <= '0;
      end else if (w_in_wait) begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= WAIT_X;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      WAIT_X: begin
        if (auto_mode)       w_next = w_auto_first;
        else if (!key_n[0])  w_next = LOAD_X;
      end
      LOAD_X:   w_next = WAIT_Y;
      WAIT_Y:   if (!key_n[1]) w_next = LOAD_Y;
      LOAD_Y:   w_next = WAIT_A;
      WAIT_A:   if (!key_n[2]) w_next = LOAD_A;
      LOAD_A:   w_next = START_LL;
      START_LL: w_next = WAIT_LL;
      WAIT_LL: begin
        if (ll_done)        w_next = START_DG;
        else if (w_timeout) w_next = DONE;
      end
      START_DG: w_next = WAIT_DG;
      WAIT_DG: begin
        if (dg_done)        w_next = START_RT;
        else if (w_timeout) w_next = DONE;
      end
      START_RT: w_next = WAIT_RT;
      WAIT_RT: begin
        if (rt_done || w_timeout) w_next = DONE;
      end
      DONE:     w_next = auto_mode ? w_auto_first : WAIT_X;
      default:  w_next = WAIT_X;
    endcase
  end

  // Combinational outputs: start pulses and grid-port ownership
  always_comb begin
    ll_start   = (r_state == START_LL);
    dg_start   = (r_state == START_DG);
    rt_start   = (r_state == START_RT);
    grid_x     = '0;
    grid_y     = '0;
    grid_in    = '0;
    grid_write = 1'b0;
    case (r_state)
      WAIT_LL: begin
        grid_x     = ll_gx;
        grid_y     = ll_gy;
        grid_in    = ll_gin;
        grid_write = ll_gwrite;
      end
      WAIT_DG: begin
        grid_x = dg_gx;
        grid_y = dg_gy;
      end
      WAIT_RT: begin
        grid_x = rt_gx;
        grid_y = rt_gy;
      end
      default: ;
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge clock) begin
    if (reset) begin
      r_x           <= '0;
      r_y           <= '0;
      r_angle       <= '0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
      r_busy        <= 1'b0;
      r_level       <= '0;
      r_level_vld   <= 1'b0;
    end else begin
      // frame_done/frame_count update on the edge into DONE, so the pulse
      // coincides with the DONE state; a watchdog exit never reaches here.
      r_frame_done <= (r_state == WAIT_RT) && rt_done;
      if ((r_state == WAIT_RT) && rt_done) begin
        r_frame_count <= r_frame_count + 8'd1;
      end

      r_busy <= (w_next == START_LL) || (w_next == WAIT_LL) ||
                (w_next == START_DG) || (w_next == WAIT_DG) ||
                (w_next == START_RT) || (w_next == WAIT_RT);

      if (r_state == LOAD_X) r_x     <= data[X_WIDTH-1:0];
      if (r_state == LOAD_Y) r_y     <= data[Y_WIDTH-1:0];
      if (r_state == LOAD_A) r_angle <= data[ANGLE_WIDTH-1:0];
      if (auto_mode && ((r_state == WAIT_X) || (r_state == DONE))) begin
        r_x     <= pose_x;
        r_y     <= pose_y;
        r_angle <= pose_angle;
      end

      if ((r_state == WAIT_LL) && ll_done) begin
        r_level     <= level;
        r_level_vld <= 1'b1;
      end
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign angle       = r_angle;
  assign frame_done  = r_frame_done;
  assign frame_count = r_frame_count;
  assign busy        = r_busy;
  assign state_dbg   = r_state;

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer
//   Scoreboard bench for frame_sequencer. Stimulus threads push the expected
//   start-pulse order and per-frame results; monitors pop and compare when the
//   DUT raises a start pulse or frame_done. The reference keeps only the frame
//   rules: pose per frame, level-load needed when the level differs from the
//   last loaded one, counter modulo 256.
`timescale 1ns/1ps

module tb_frame_sequencer;
  localparam int DW = 14, XW = 14, YW = 13, AW = 8, GXW = 6, GYW = 5, CW = 3;

  logic           clock = 1'b0;
  logic           reset;
  logic [2:0]     key_n;
  logic [DW-1:0]  data;
  logic           auto_mode;
  logic [XW-1:0]  pose_x;
  logic [YW-1:0]  pose_y;
  logic [AW-1:0]  pose_angle;
  logic [1:0]     level;
  logic           ll_start, dg_start, rt_start;
  logic           ll_done, dg_done, rt_done;
  logic           ll_resp = 1'b0, dg_resp = 1'b0, rt_resp = 1'b0;
  logic           dg_force = 1'b0, rt_force = 1'b0;
  logic [GXW-1:0] ll_gx, dg_gx, rt_gx, grid_x;
  logic [GYW-1:0] ll_gy, dg_gy, rt_gy, grid_y;
  logic [CW-1:0]  ll_gin, grid_in;
  logic           ll_gwrite, grid_write;
  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic [AW-1:0]  angle;
  logic           frame_done;
  logic [7:0]     frame_count;
  logic           busy;
  logic           timeout_err;
  logic [3:0]     state_dbg;

  assign ll_done = ll_resp;
  assign dg_done = dg_resp | dg_force;
  assign rt_done = rt_resp | rt_force;

  frame_sequencer #(
    .DATA_WIDTH(DW), .X_WIDTH(XW), .Y_WIDTH(YW), .ANGLE_WIDTH(AW),
    .GX_WIDTH(GXW), .GY_WIDTH(GYW), .CELL_WIDTH(CW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clock), .reset(reset), .key_n(key_n), .data(data),
    .auto_mode(auto_mode), .pose_x(pose_x), .pose_y(pose_y),
    .pose_angle(pose_angle), .level(level),
    .ll_start(ll_start), .dg_start(dg_start), .rt_start(rt_start),
    .ll_done(ll_done), .dg_done(dg_done), .rt_done(rt_done),
    .ll_gx(ll_gx), .ll_gy(ll_gy), .ll_gin(ll_gin), .ll_gwrite(ll_gwrite),
    .dg_gx(dg_gx), .dg_gy(dg_gy), .rt_gx(rt_gx), .rt_gy(rt_gy),
    .grid_x(grid_x), .grid_y(grid_y), .grid_in(grid_in), .grid_write(grid_write),
    .x(x), .y(y), .angle(angle), .frame_done(frame_done),
    .frame_count(frame_count), .busy(busy), .timeout_err(timeout_err),
    .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s", name, what);
  endtask

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    int x;
    int y;
    int a;
    int cnt;
  } frame_t;

  frame_t q_frame[$];
  int     q_start[$];   // 1 = ll, 2 = dg, 4 = rt
  int     m_cnt = 0;
  bit     m_vld = 0;
  int     m_lvl = 0;
  int     lv_plan[$];

  function automatic void exp_frame(input bit need_ll, input int ex, input int ey, input int ea);
    frame_t f;
    if (need_ll) q_start.push_back(1);
    q_start.push_back(2);
    q_start.push_back(4);
    m_cnt = (m_cnt + 1) % 256;
    f.x = ex; f.y = ey; f.a = ea; f.cnt = m_cnt;
    q_frame.push_back(f);
  endfunction

  // ---------------- stage responders ----------------
  int ll_dly = 0, dg_dly = 0, rt_dly = 0;
  bit rt_hold = 0;

  initial forever begin
    int d;
    @(negedge clock);
    if (ll_start) begin
      d = (ll_dly != 0) ? ll_dly : int'($urandom_range(1, 5));
      repeat (d) @(posedge clock);
      #1 ll_resp = 1'b1;
      @(posedge clock);
      #1 ll_resp = 1'b0;
    end
  end

  initial forever begin
    int d;
    @(negedge clock);
    if (dg_start) begin
      d = (dg_dly != 0) ? dg_dly : int'($urandom_range(1, 5));
      repeat (d) @(posedge clock);
      #1 dg_resp = 1'b1;
      @(posedge clock);
      #1 dg_resp = 1'b0;
    end
  end

  initial forever begin
    int d;
    @(negedge clock);
    if (rt_start && !rt_hold) begin
      d = (rt_dly != 0) ? rt_dly : int'($urandom_range(1, 5));
      repeat (d) @(posedge clock);
      #1 rt_resp = 1'b1;
      @(posedge clock);
      #1 rt_resp = 1'b0;
    end
  end

  // Grid client inputs change every cycle.
  always @(posedge clock) begin
    #1;
    ll_gx = GXW'($urandom); ll_gy = GYW'($urandom);
    ll_gin = CW'($urandom); ll_gwrite = 1'($urandom);
    dg_gx = GXW'($urandom); dg_gy = GYW'($urandom);
    rt_gx = GXW'($urandom); rt_gy = GYW'($urandom);
  end

  // ---------------- monitors ----------------
  always @(negedge clock) begin
    logic [2:0] st;
    frame_t     e;
    st = {rt_start, dg_start, ll_start};
    if (st != 3'b000) begin
      if (q_start.size() == 0) fail_now("start_unexpected", $sformatf("got starts %b expected none", st));
      else chk("start_order", longint'(st), longint'(q_start.pop_front()));
    end
    if (frame_done) begin
      if (q_frame.size() == 0) begin
        fail_now("frame_unexpected", "got frame_done expected none");
      end else begin
        e = q_frame.pop_front();
        chk("frame_x", longint'(x), longint'(e.x));
        chk("frame_y", longint'(y), longint'(e.y));
        chk("frame_angle", longint'(angle), longint'(e.a));
        chk("frame_count", longint'(frame_count), longint'(e.cnt));
      end
    end
  end

  int g_own = 0;
  always @(negedge clock) begin
    logic [14:0] act;
    act = {grid_x, grid_y, grid_in, grid_write};
    if (g_own == 1)      chk("grid_ll", longint'(act), longint'({ll_gx, ll_gy, ll_gin, ll_gwrite}));
    else if (g_own == 2) chk("grid_dg", longint'(act), longint'({dg_gx, dg_gy, 4'b0000}));
    else if (g_own == 3) chk("grid_rt", longint'(act), longint'({rt_gx, rt_gy, 4'b0000}));
    g_own = 0;
    if (ll_start || dg_start || rt_start || frame_done) chk("grid_idle", longint'(act), 0);
    if (ll_start)      g_own = 1;
    else if (dg_start) g_own = 2;
    else if (rt_start) g_own = 3;
  end

  // ---------------- stimulus helpers ----------------
  task automatic press(input int idx, input logic [DW-1:0] val);
    @(posedge clock);
    #1 data = val;
    key_n = 3'b111 & ~(3'b001 << idx);
    @(posedge clock);
    @(posedge clock);
    #1 key_n = 3'b111;
  endtask

  task automatic keys3(input logic [DW-1:0] dx, input logic [DW-1:0] dy, input logic [DW-1:0] da);
    press(0, dx);
    press(1, dy);
    press(2, da);
  endtask

  task automatic manual_frame(input logic [DW-1:0] dx, input logic [DW-1:0] dy, input logic [DW-1:0] da);
    logic [YW-1:0] ty;
    logic [AW-1:0] ta;
    ty = dy[YW-1:0];
    ta = da[AW-1:0];
    exp_frame(1'b1, int'(dx), int'(ty), int'(ta));
    m_vld = 1; m_lvl = int'(level);
    keys3(dx, dy, da);
  endtask

  task automatic wait_start(input int which, input int budget);
    bit found;
    found = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      if ((which == 1 && ll_start) || (which == 2 && dg_start) || (which == 4 && rt_start)) begin
        found = 1;
        break;
      end
    end
    if (!found) fail_now("wait_start", $sformatf("no start %0d within %0d cycles", which, budget));
  endtask

  task automatic wait_drain(input int budget);
    bit ok;
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      if (q_start.size() == 0 && q_frame.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("drain", $sformatf("%0d starts / %0d frames still pending", q_start.size(), q_frame.size()));
    repeat (2) @(negedge clock);
  endtask

  task automatic set_auto_frame();
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic [AW-1:0] pa;
    bit need;
    px = XW'($urandom); py = YW'($urandom); pa = AW'($urandom);
    pose_x = px; pose_y = py; pose_angle = pa;
    if (lv_plan.size() != 0) level = 2'(lv_plan.pop_front());
    else if ($urandom_range(0, 3) == 0) level = 2'($urandom);
    need = !m_vld || (int'(level) != m_lvl);
    if (need) begin
      m_vld = 1;
      m_lvl = int'(level);
    end
    exp_frame(need, int'(px), int'(py), int'(pa));
  endtask

  task automatic run_auto(input int nframes);
    @(posedge clock);
    #1 set_auto_frame();
    auto_mode = 1'b1;
    for (int f = 0; f < nframes; f++) begin
      wait_start(2, 200);
      if (f < nframes - 1) set_auto_frame();
      else auto_mode = 1'b0;
    end
    wait_drain(300);
  endtask

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; key_n = 3'b111; data = '0; auto_mode = 1'b0;
    pose_x = '0; pose_y = '0; pose_angle = '0; level = 2'd2;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    @(negedge clock);
    chk("rst_state", longint'(state_dbg), 0);
    chk("rst_x", longint'(x), 0);
    chk("rst_y", longint'(y), 0);
    chk("rst_angle", longint'(angle), 0);
    chk("rst_count", longint'(frame_count), 0);
    chk("rst_timeout", longint'(timeout_err), 0);
    chk("rst_pulses", longint'({frame_done, ll_start, dg_start, rt_start}), 0);

    // Manual frame with fixed 5-cycle stage latency
    ll_dly = 5; dg_dly = 5; rt_dly = 5;
    manual_frame(14'h0123, 14'h0123, 14'h0123);
    wait_drain(300);
    ll_dly = 0; dg_dly = 0; rt_dly = 0;

    // Random manual frames
    for (int i = 0; i < 3; i++) begin
      level = 2'($urandom);
      manual_frame(DW'($urandom), DW'($urandom), DW'($urandom));
      wait_drain(300);
    end

    // Stray done inputs while the level loader is running
    ll_dly = 8;
    manual_frame(DW'($urandom), DW'($urandom), DW'($urandom));
    wait_start(1, 200);
    @(posedge clock);
    #1 dg_force = 1'b1; rt_force = 1'b1;
    @(posedge clock);
    #1 dg_force = 1'b0; rt_force = 1'b0;
    @(negedge clock);
    chk("stray_done_state", longint'(state_dbg), 7);
    wait_drain(300);
    ll_dly = 0;

    // Reset in WAIT_DG with dg_done high
    dg_dly = 10;
    q_start.push_back(1);
    q_start.push_back(2);
    keys3(DW'($urandom), DW'($urandom), DW'($urandom));
    wait_start(2, 200);
    @(posedge clock);
    #1 reset = 1'b1; dg_force = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0; dg_force = 1'b0;
    m_cnt = 0; m_vld = 0; m_lvl = 0;
    @(negedge clock);
    chk("midrst_state", longint'(state_dbg), 0);
    chk("midrst_count", longint'(frame_count), 0);
    chk("midrst_x", longint'(x), 0);
    repeat (15) @(negedge clock);
    chk("midrst_queue", longint'(q_start.size()), 0);
    dg_dly = 0;

    // Auto mode: level 2 twice (second skips LL), then level 1 reloads
    lv_plan.push_back(2);
    lv_plan.push_back(2);
    lv_plan.push_back(1);
    run_auto(3);

    // Long auto run to wrap frame_count
    run_auto(257);
    chk("wrap_count", longint'(frame_count), longint'(m_cnt));

`ifdef FRAME_SEQUENCER_TIMEOUT_EN
    rt_hold = 1;
    q_start.push_back(1);
    q_start.push_back(2);
    q_start.push_back(4);
    m_vld = 1; m_lvl = int'(level);
    keys3(DW'($urandom), DW'($urandom), DW'($urandom));
    wait_start(4, 200);
    repeat (17) @(negedge clock);
    chk("timeout_set", longint'(timeout_err), 1);
    repeat (4) @(negedge clock);
    chk("timeout_count", longint'(frame_count), longint'(m_cnt));
    chk("timeout_idle_state", longint'(state_dbg), 0);
    rt_hold = 0;
`else
    chk("timeout_off", longint'(timeout_err), 0);
`endif

    wait_drain(100);
    chk("final_count", longint'(frame_count), longint'(m_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, 14: switch data bus width
- X_WIDTH, 14: pose X width
- Y_WIDTH, 13: pose Y width
- ANGLE_WIDTH, 8: angle width
- GX_WIDTH, 6: grid X width
- GY_WIDTH, 5: grid Y width
- CELL_WIDTH, 3: grid cell width
- TIMEOUT_CYCLES, 2^20: stage watchdog limit

X_WIDTH, Y_WIDTH and ANGLE_WIDTH SHALL each be <= DATA_WIDTH.

REQ-002 Ports SHALL be:
- clock  in  1  sole clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high
- key_n  in  3  active-low load buttons; bit0 = X, bit1 = Y, bit2 = angle
- data  in  DATA_WIDTH  manual pose data
- auto_mode  in  1  1 = continuous frames from pose_*
- pose_x/pose_y/pose_angle  in  X/Y/ANGLE_WIDTH  auto-mode pose
- level  in  2  level select
- ll_start/dg_start/rt_start  out  1  one-cycle stage start pulses (level loader, draw grid, raytracer)
- ll_done/dg_done/rt_done  in  1  stage done, level-sampled
- ll_gx/ll_gy/ll_gin/ll_gwrite  in  GX/GY/CELL/1  level-loader grid port
- dg_gx/dg_gy, rt_gx/rt_gy  in  GX/GY  read-only client grid addresses
- grid_x/grid_y/grid_in/grid_write  out  GX/GY/CELL/1  muxed grid port
- x/y/angle  out  X/Y/ANGLE_WIDTH  registered pose
- frame_done  out  1  one-cycle pulse per completed frame
- frame_count  out  8  completed frames, wraps 255 -> 0
- busy  out  1  high in any START_*/WAIT_* state
- timeout_err  out  1  sticky watchdog flag
- state_dbg  out  4  current state encoding

Function
REQ-003 States SHALL be WAIT_X, LOAD_X, WAIT_Y, LOAD_Y, WAIT_A, LOAD_A, START_LL, WAIT_LL, START_DG, WAIT_DG, START_RT, WAIT_RT, DONE, in encodings 0-12.
REQ-004 In manual mode (auto_mode = 0), transitions SHALL be:
- WAIT_X -> LOAD_X when key_n[0] = 0; WAIT_Y -> LOAD_Y on key_n[1] = 0; WAIT_A -> LOAD_A on key_n[2] = 0.
- Each LOAD_* -> next WAIT_*/START_* after exactly one cycle.
REQ-005 In LOAD_X, LOAD_Y and LOAD_A, x, y and angle SHALL capture data[X_WIDTH-1:0], data[Y_WIDTH-1:0] and data[ANGLE_WIDTH-1:0] respectively.
REQ-006 START_LL, START_DG and START_RT SHALL each last one cycle, assert the matching *_start, and advance to the matching WAIT_* state.
REQ-007 WAIT_LL -> START_DG, WAIT_DG -> START_RT and WAIT_RT -> DONE SHALL each occur on the first cycle the matching done input is 1.
REQ-008 DONE SHALL pulse frame_done, increment frame_count, and go to WAIT_X when auto_mode = 0, or to START_LL when auto_mode = 1.
REQ-009 When auto_mode = 1 in WAIT_X or DONE, x, y and angle SHALL load from pose_* in that cycle, and keys SHALL be ignored.
REQ-010 In auto mode, START_LL SHALL be skipped (direct to START_DG) when level equals the level latched at the last completed level load; the first frame after reset always loads.
REQ-011 Grid port owner SHALL be: WAIT_LL -> level-loader client; WAIT_DG -> draw-grid client; WAIT_RT -> raytracer client. In all other states, grid_x, grid_y, grid_in and grid_write SHALL be 0.
REQ-012 grid_write and grid_in SHALL be 0 whenever the level loader is not the owner.
REQ-013 A done input asserted outside its own WAIT_* state SHALL be ignored.
REQ-014 The grid mux and *_start outputs SHALL be combinational from state; all other outputs SHALL be registered.

Reset
REQ-015 On reset = 1 at a clock edge:
- state = WAIT_X
- x, y, angle, frame_count, timeout_err, latched level = 0
- level-latch valid flag cleared
- all pulses 0
REQ-016 Reset SHALL take priority over every event, including mid-stage; no *_start pulse SHALL follow a reset.

Configuration
REQ-017 Macro FRAME_SEQUENCER_TIMEOUT_EN defined: a cycle counter SHALL clear on entry to each WAIT_LL/DG/RT state. When the counter reaches TIMEOUT_CYCLES with done still 0, the block SHALL set timeout_err and go to DONE without pulsing frame_done or incrementing frame_count.
REQ-018 Macro undefined: no counter SHALL be present, timeout_err SHALL be constant 0, and WAIT_* states SHALL wait indefinitely.

Verification
REQ-019 Manual frame: data = 0x0123 with key_n = 3'b110, then 3'b101, then 3'b011; done inputs return 5 cycles after each start. Required: x = 0x0123, y = 0x0123, angle = 0x23; ll/dg/rt starts in order; one frame_done pulse; frame_count = 1.
REQ-020 Grid mux: in WAIT_LL, drive ll_gx = 5, ll_gwrite = 1, ll_gin = 3, and rt_gx = 9. Required: grid_x = 5, grid_write = 1, grid_in = 3. In WAIT_RT: grid_x = 9, grid_write = 0, grid_in = 0.
REQ-021 Auto mode with level held at 2 for two frames. Required: ll_start in frame 1 only; pose_* captured each frame. Changing level to 1 SHALL produce ll_start again.
REQ-022 Assert reset in WAIT_DG while dg_done = 1. Required: next state = WAIT_X, no rt_start, frame_count = 0.
REQ-023 With FRAME_SEQUENCER_TIMEOUT_EN defined and TIMEOUT_CYCLES = 16, hold rt_done = 0. Required: timeout_err = 1 within 17 cycles of WAIT_RT entry; frame_count unchanged.
REQ-024 Drive 256 frames. Required: frame_count wraps to 0; a stray dg_done during WAIT_LL does not advance state.
